// File: rtl/reset_release_sequencer.sv
// Synchronizes the release of an incoming asynchronous reset, then releases a bank of
// per-subsystem resets one at a time, with a fixed spacing between releases.
module reset_release_sequencer #(
    parameter int NUMBER_OF_STAGES = 4,
    parameter int STAGE_DELAY_LOG2 = 4,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        hold,
    output logic [NUMBER_OF_STAGES-1:0] stage_reset,
    output logic                        ready,
    output logic [7:0]                  hold_count
);

    // state     | meaning
    // WAIT_SYNC | waiting for the deassertion synchronizer to clear; hold ignored
    // RELEASE   | spacing timer running, stages released in index order
    // RUN       | all stages released, outputs steady
    // HELD      | hold asserted, all stages back in reset
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HELD      = 2'd3
    } state_t;

    localparam int INDEX_WIDTH = (NUMBER_OF_STAGES > 1) ? $clog2(NUMBER_OF_STAGES) : 1;
    localparam logic [STAGE_DELAY_LOG2-1:0] COUNT_LAST = '1;
    localparam logic [INDEX_WIDTH-1:0]      INDEX_LAST = INDEX_WIDTH'(NUMBER_OF_STAGES - 1);

    state_t                        state;
    state_t                        state_next;
    logic [SYNC_STAGES-1:0]        sync_chain;
    logic                          sync_reset;
    logic [STAGE_DELAY_LOG2-1:0]   counter;
    logic [STAGE_DELAY_LOG2-1:0]   counter_next;
    logic [INDEX_WIDTH-1:0]        index;
    logic [INDEX_WIDTH-1:0]        index_next;
    logic [NUMBER_OF_STAGES-1:0]   stage_reset_next;
    logic                          ready_next;
    logic                          hold_prev;
    logic                          release_due;
    logic                          enter_held;

    assign sync_reset  = sync_chain[SYNC_STAGES-1];
    assign release_due = (counter == COUNT_LAST);
    assign enter_held  = hold && ((state == RELEASE) || (state == RUN));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // WAIT_SYNC leaves on the same edge that sync_reset falls, so the first
    // release lands a full spacing period after the synchronizer clears.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SYNC: begin
                if (!sync_reset || !sync_chain[SYNC_STAGES-2]) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (hold) begin
                    state_next = HELD;
                end else if (release_due && (index == INDEX_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (hold) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (!hold) begin
                    state_next = RELEASE;
                end
            end
            default: state_next = WAIT_SYNC;
        endcase
    end

    always_comb begin
        stage_reset_next = stage_reset;
        ready_next       = ready;
        counter_next     = counter;
        index_next       = index;
        case (state)
            WAIT_SYNC: begin
                counter_next = '0;
                index_next   = '0;
            end
            RELEASE: begin
                if (release_due) begin
                    stage_reset_next = stage_reset & ~(NUMBER_OF_STAGES'(1) << index);
                    counter_next     = '0;
                    index_next       = index + INDEX_WIDTH'(1);
                    if (index == INDEX_LAST) begin
                        ready_next = 1'b1;
                    end
                end else begin
                    counter_next = counter + STAGE_DELAY_LOG2'(1);
                end
            end
            RUN: begin
                counter_next = '0;
            end
            HELD: begin
                stage_reset_next = '1;
                ready_next       = 1'b0;
                counter_next     = '0;
                index_next       = '0;
            end
            default: begin
                stage_reset_next = '1;
                ready_next       = 1'b0;
                counter_next     = '0;
                index_next       = '0;
            end
        endcase
        // A hold overrides any release scheduled for the same edge.
        if (enter_held) begin
            stage_reset_next = '1;
            ready_next       = 1'b0;
            counter_next     = '0;
            index_next       = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_chain  <= '1;
            stage_reset <= '1;
            ready       <= 1'b0;
            counter     <= '0;
            index       <= '0;
            hold_prev   <= 1'b0;
            hold_count  <= 8'd0;
        end else begin
            sync_chain  <= {sync_chain[SYNC_STAGES-2:0], 1'b0};
            stage_reset <= stage_reset_next;
            ready       <= ready_next;
            counter     <= counter_next;
            index       <= index_next;
            hold_prev   <= hold;
            if (hold && !hold_prev && (state != WAIT_SYNC) && (hold_count != 8'hFF)) begin
                hold_count <= hold_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: power-on vector table, directed hold/reset corner
// cases, then randomized hold/reset traffic checked against an edge-arithmetic model.
module tb_reset_release_sequencer;

    localparam int N     = 4;
    localparam int DLOG2 = 2;
    localparam int SYNC  = 2;
    localparam int SPACE = 1 << DLOG2;

    logic         clock;
    logic         reset;
    logic         hold;
    logic [N-1:0] stage_reset;
    logic         ready;
    logic [7:0]   hold_count;

    int checks = 0;
    int fails  = 0;

    reset_release_sequencer #(
        .NUMBER_OF_STAGES(N),
        .STAGE_DELAY_LOG2(DLOG2),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hold(hold),
        .stage_reset(stage_reset),
        .ready(ready),
        .hold_count(hold_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: edges since reset fell, and the edge from which release spacing is counted.
    int m_edge  = 0;
    bit m_held  = 0;
    int m_base  = SYNC;
    int m_count = 0;
    bit m_prev  = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_edge  = 0;
            m_held  = 0;
            m_base  = SYNC;
            m_count = 0;
            m_prev  = 0;
        end else begin
            m_edge = m_edge + 1;
            if (m_edge > SYNC) begin
                if (m_held) begin
                    if (!hold) begin
                        m_held = 0;
                        m_base = m_edge;
                    end
                end else if (hold) begin
                    m_held = 1;
                end
                if (hold && !m_prev && m_count < 255) m_count = m_count + 1;
            end
            m_prev = hold;
        end
    end

    function automatic logic [N-1:0] model_stage();
        logic [N-1:0] s;
        s = '1;
        if (!m_held) begin
            for (int k = 0; k < N; k++) begin
                if (m_edge >= m_base + (k + 1) * SPACE) s[k] = 1'b0;
            end
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, m_edge);
        end
    endtask

    task automatic step_to(input int n);
        int guard;
        guard = 0;
        while (m_edge < n && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (m_edge != n) begin
            checks++;
            fails++;
            $display("FAIL step_to: at edge %0d expected edge %0d", m_edge, n);
        end
    endtask

    task automatic short_reset();
        reset = 1'b1;
        #1;
        check("reset_async_stage", 32'(stage_reset), 32'hF);
        check("reset_async_ready", 32'(ready), 32'd0);
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        int           edge_n;
        logic [N-1:0] stage;
        logic         rdy;
    } vec_t;

    vec_t vecs [0:9];

    initial begin
        int f;
        int r;
        vecs[0] = '{1,  4'b1111, 1'b0};
        vecs[1] = '{5,  4'b1111, 1'b0};
        vecs[2] = '{6,  4'b1110, 1'b0};
        vecs[3] = '{9,  4'b1110, 1'b0};
        vecs[4] = '{10, 4'b1100, 1'b0};
        vecs[5] = '{13, 4'b1100, 1'b0};
        vecs[6] = '{14, 4'b1000, 1'b0};
        vecs[7] = '{17, 4'b1000, 1'b0};
        vecs[8] = '{18, 4'b0000, 1'b1};
        vecs[9] = '{20, 4'b0000, 1'b1};

        reset = 1'b0;
        hold  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("por_stage", 32'(stage_reset), 32'hF);
        check("por_ready", 32'(ready), 32'd0);
        check("por_hold_count", 32'(hold_count), 32'd0);

        // Power-on release table
        repeat (5) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_to(vecs[i].edge_n);
            check($sformatf("table_stage_e%0d", vecs[i].edge_n), 32'(stage_reset), 32'(vecs[i].stage));
            check($sformatf("table_ready_e%0d", vecs[i].edge_n), 32'(ready), 32'(vecs[i].rdy));
        end
        check("table_hold_count", 32'(hold_count), 32'd0);

        // Reset pulse mid-sequence
        short_reset();
        step_to(11);
        check("mid_pre_stage", 32'(stage_reset), 32'hC);
        short_reset();
        step_to(5);
        check("mid_restart_e5", 32'(stage_reset), 32'hF);
        step_to(6);
        check("mid_restart_e6", 32'(stage_reset), 32'hE);
        step_to(18);
        check("mid_done_stage", 32'(stage_reset), 32'h0);
        check("mid_done_ready", 32'(ready), 32'd1);

        // Hold in RUN
        hold = 1'b1;
        step_to(19);
        check("hold_run_stage", 32'(stage_reset), 32'hF);
        check("hold_run_ready", 32'(ready), 32'd0);
        check("hold_run_count", 32'(hold_count), 32'd1);
        step_to(21);
        check("hold_kept_stage", 32'(stage_reset), 32'hF);
        hold = 1'b0;
        f = 22;
        step_to(f + 3);
        check("hold_f3", 32'(stage_reset), 32'hF);
        step_to(f + 4);
        check("hold_f4", 32'(stage_reset), 32'hE);
        step_to(f + 15);
        check("hold_f15_stage", 32'(stage_reset), 32'h8);
        check("hold_f15_ready", 32'(ready), 32'd0);
        step_to(f + 16);
        check("hold_f16_stage", 32'(stage_reset), 32'h0);
        check("hold_f16_ready", 32'(ready), 32'd1);
        check("hold_f16_count", 32'(hold_count), 32'd1);

        // Hold colliding with the final release
        hold = 1'b1;
        step_to(f + 17);
        hold = 1'b0;
        f = f + 18;
        step_to(f + 15);
        check("coll_pre_stage", 32'(stage_reset), 32'h8);
        hold = 1'b1;
        step_to(f + 16);
        check("coll_stage", 32'(stage_reset), 32'hF);
        check("coll_ready", 32'(ready), 32'd0);
        check("coll_count", 32'(hold_count), 32'd3);
        hold = 1'b0;

        // Saturation
        repeat (300) begin
            @(negedge clock);
            hold = 1'b1;
            @(negedge clock);
            hold = 1'b0;
        end
        @(negedge clock);
        check("sat_count", 32'(hold_count), 32'd255);
        reset = 1'b1;
        #1;
        check("sat_cleared", 32'(hold_count), 32'd0);
        #2;
        reset = 1'b0;

        // Hold asserted during reset and WAIT_SYNC
        @(negedge clock);
        reset = 1'b1;
        hold  = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        step_to(4);
        check("hdr_count_e4", 32'(hold_count), 32'd0);
        check("hdr_stage_e4", 32'(stage_reset), 32'hF);
        hold = 1'b0;
        f = 5;
        step_to(f + 3);
        check("hdr_f3", 32'(stage_reset), 32'hF);
        step_to(f + 4);
        check("hdr_f4", 32'(stage_reset), 32'hE);
        step_to(f + 16);
        check("hdr_f16_stage", 32'(stage_reset), 32'h0);
        check("hdr_f16_ready", 32'(ready), 32'd1);
        check("hdr_count", 32'(hold_count), 32'd0);

        // Randomized hold/reset traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            check("rand_stage", 32'(stage_reset), 32'(model_stage()));
            check("rand_ready", 32'(ready), 32'(model_stage() == '0));
            check("rand_count", 32'(hold_count), 32'(m_count));
            r = int'($urandom_range(0, 299));
            if (reset) begin
                if (r < 100) reset = 1'b0;
            end else if (r == 0) begin
                reset = 1'b1;
                #($urandom_range(1, 3));
                reset = 1'b0;
            end else if (r == 1) begin
                reset = 1'b1;
            end
            if (hold) begin
                if ($urandom_range(0, 2) == 0) hold = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) hold = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reset_release_sequencer.md
# reset_release_sequencer

Receiving end of the reset generator's `downstream_reset`, clocked by the PLL output clock. It synchronizes deassertion of the asynchronous incoming reset, then releases a bank of per-subsystem resets one at a time with a fixed spacing. It reports when every subsystem is out of reset, and accepts a synchronous hold request that re-asserts and re-sequences all resets.

## Interface

Parameters:
- `NUMBER_OF_STAGES`, 4: number of independently released reset outputs (1..16).
- `STAGE_DELAY_LOG2`, 4: spacing between releases is 2^STAGE_DELAY_LOG2 cycles (≥1).
- `SYNC_STAGES`, 2: length of the deassertion synchronizer chain (≥2).

Ports:
- `clock`, in, 1: PLL output clock. One clock; reset is asynchronous and active-high.
- `reset`, in, 1: asynchronous, active-high; driven by the reset generator's `downstream_reset`.
- `hold`, in, 1: synchronous to `clock`; 1 forces all stages back into reset.
- `stage_reset`, out, NUMBER_OF_STAGES: per-subsystem active-high resets; bit 0 is released first.
- `ready`, out, 1: 1 when all stages are released.
- `hold_count`, out, 8: saturating count of `hold` rising edges since `reset`.

## Operation

- Reset values: `stage_reset`=all ones, `ready`=0, `hold_count`=0, synchronizer chain all ones, delay counter 0, stage index 0, state HOLD.
- Assertion of `reset` forces these values asynchronously, with no clock edge needed.
- Synchronizer: the chain of SYNC_STAGES flops is asynchronously preset by `reset` and shifts in 0 each edge. `sync_reset` is the last flop.
- State machine:
  - WAIT_SYNC (the HOLD state after reset): wait for `sync_reset`=0, then go to RELEASE with counter=0 and index=0.
  - RELEASE: the counter (STAGE_DELAY_LOG2 bits) increments each cycle.
    - When counter = 2^STAGE_DELAY_LOG2−1: clear `stage_reset[index]`, set counter to 0, increment index.
    - When index = NUMBER_OF_STAGES−1 is cleared: set `ready`=1 on the same edge and go to RUN.
  - RUN: hold outputs steady.
  - HELD: entered from RELEASE or RUN when `hold`=1.
    - On that edge: `stage_reset`=all ones, `ready`=0, counter=0, index=0.
    - Remain while `hold`=1. On the first cycle with `hold`=0, go to RELEASE. The synchronizer is not re-run.
- `hold` is ignored in WAIT_SYNC (including while `reset` is asserted).
- `hold` wins over a release scheduled on the same edge.
- `hold_count`:
  - Increments when `hold`=1 and the registered previous `hold`=0, in any state other than WAIT_SYNC.
  - Saturates at 255 and is cleared only by `reset`.
- Released bits stay released until `reset` or `hold`. Bits never release out of order.

## Timing

- Edge 1 is the first rising edge after `reset` falls.
- `sync_reset` goes to 0 at edge SYNC_STAGES.
- `stage_reset[k]` clears at edge SYNC_STAGES + (k+1)·2^STAGE_DELAY_LOG2.
- `ready` rises at the same edge as the last stage clears.
- From `hold` falling (first low-sampling edge F): `stage_reset[k]` clears at edge F + (k+1)·2^STAGE_DELAY_LOG2.
- Latency of the `hold` response: 1 edge. `hold_count` updates on that same edge.
- A `reset` pulse of any width, including one shorter than a clock period, sets outputs to reset values immediately and restarts the full sequence from edge 1 after it falls.
- `reset` asserted mid-RELEASE aborts the sequence; no partially released state survives.
- All outputs are registered, with no combinational path from `hold`.

## Test plan

Parameters for all scenarios: NUMBER_OF_STAGES=4, STAGE_DELAY_LOG2=2, SYNC_STAGES=2.

- Power-on: `reset`=1 for 5 cycles, then 0 → `stage_reset`=1111 until edge 6, then 1110 at edge 6, 1100 at 10, 1000 at 14, 0000 at 18 with `ready`=1; `hold_count`=0.
- Reset mid-sequence: `reset` pulses 1 for 3 ns between edges 11 and 12 → `stage_reset`=1111 and `ready`=0 immediately; the release sequence restarts from edge 1 after the fall, with 1110 at edge 6.
- Hold in RUN: `hold`=1 sampled at edge E → 1111, `ready`=0, `hold_count`=1 after E. `hold`=0 first sampled at F → 1110 at F+4, 0000 and `ready`=1 at F+16.
- Hold collision: `hold`=1 sampled at the edge scheduled to clear bit 3 → `stage_reset` goes to 1111 and `ready` stays 0.
- Saturation: 300 single-cycle `hold` pulses separated by ≥1 low cycle → `hold_count`=255. `reset` → `hold_count`=0.
- Hold during reset: `hold`=1 while `reset`=1 and throughout WAIT_SYNC → `hold_count` stays 0, and the sequence proceeds as in the power-on case only after `hold` is low.
